// File: rtl/uop_latch_pkg.sv
// ---------------------------------------------------------------------------
// uop_latch_pkg
// Shared types and helpers for the uop_latch_bank slice.
//   latch_state_t   : bus-turnaround FSM state encoding
//   TA_W            : width of the turnaround down-counter
//   chan_sel_width  : channel-select width, never less than one bit
// ---------------------------------------------------------------------------
package uop_latch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } latch_state_t;

  localparam int TA_W = 4;

  // A single-channel bank still needs a one-bit SEL port.
  function automatic int chan_sel_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uop_latch_reg.sv
// ---------------------------------------------------------------------------
// uop_latch_reg
// One WIDTH-bit storage channel. Loads d on a rising clk edge when le is
// high, otherwise holds. Synchronous active-high reset to RESET_VAL.
//   clk   : clock
//   reset : synchronous active-high reset
//   le    : load enable, sampled at the clock edge
//   d     : data in
//   q     : registered channel value
// ---------------------------------------------------------------------------
module uop_latch_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             le,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (le) begin
      q <= d;
    end
  end

endmodule

// File: rtl/uop_latch_bank.sv
// ---------------------------------------------------------------------------
// uop_latch_bank
// CHANNELS independent WIDTH-bit registers with per-channel load enables.
// One selected channel drives a shared tri-state bus; whenever the driver
// changes or releases the bus, TURNAROUND high-Z dead cycles are inserted so
// two board-level drivers never overlap.
//
// Ports
//   CLK   : clock, all state updates on the rising edge
//   RESET : synchronous active-high reset, overrides everything
//   D     : data input common to all channels
//   LE    : per-channel load enable
//   SEL   : channel to put on Y
//   OE    : output-enable request (ignored when SEL is out of range)
//   Y     : tri-state bus, 'z unless driving
//   Q     : all channel values, channel i at [i*WIDTH +: WIDTH]
//   BUSY  : high during turnaround dead cycles
//   DRV   : high when Y is actively driven
//
// FSM
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_IDLE  | bus released, Y = 'z, waiting for a valid request
//   ST_DRIVE | Y driven from channel drv_ch
//   ST_TURN  | dead cycles after a release/switch, Y = 'z, count running
// ---------------------------------------------------------------------------
module uop_latch_bank
  import uop_latch_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               CHANNELS   = 4,
  parameter int               TURNAROUND = 1,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                                      CLK,
  input  logic                                      RESET,
  input  logic [WIDTH-1:0]                          D,
  input  logic [CHANNELS-1:0]                       LE,
  input  logic [uop_latch_pkg::chan_sel_width(CHANNELS)-1:0] SEL,
  input  logic                                      OE,
  output tri   [WIDTH-1:0]                          Y,
  output logic [CHANNELS*WIDTH-1:0]                 Q,
  output logic                                      BUSY,
  output logic                                      DRV
);

  localparam int CSW = chan_sel_width(CHANNELS);

  // One extra bit so CHANNELS == 2**CSW is still representable.
  localparam logic [CSW:0]      CH_LIMIT = (CSW+1)'(CHANNELS);
  localparam logic [TA_W-1:0]   TA_LOAD  = TA_W'(TURNAROUND);
  localparam logic [TA_W-1:0]   TA_LAST  = TA_W'(1);

  // -------------------------------------------------------------------------
  // Storage channels
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] ch_q [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    uop_latch_reg #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_reg (
      .clk   (CLK),
      .reset (RESET),
      .le    (LE[i]),
      .d     (D),
      .q     (ch_q[i])
    );

    assign Q[i*WIDTH +: WIDTH] = ch_q[i];
  end

  // -------------------------------------------------------------------------
  // Request decode: an out-of-range SEL behaves exactly like OE low.
  // -------------------------------------------------------------------------
  logic req;
  logic sel_is_drv;

  assign req = OE && ({1'b0, SEL} < CH_LIMIT);

  // -------------------------------------------------------------------------
  // Turnaround FSM
  // -------------------------------------------------------------------------
  latch_state_t    state,  state_nxt;
  logic [CSW-1:0]  drv_ch, drv_ch_nxt;
  logic [TA_W-1:0] count,  count_nxt;

  assign sel_is_drv = (SEL == drv_ch);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      drv_ch <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      drv_ch <= drv_ch_nxt;
      count  <= count_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    drv_ch_nxt = drv_ch;
    count_nxt  = count;

    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt  = ST_DRIVE;
          drv_ch_nxt = SEL;
        end
      end

      ST_DRIVE: begin
        if (!(req && sel_is_drv)) begin
          if (TURNAROUND > 0) begin
            state_nxt = ST_TURN;
            count_nxt = TA_LOAD;
          end else if (req) begin
            // Zero turnaround: hand the bus straight to the new channel.
            drv_ch_nxt = SEL;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      ST_TURN: begin
        // Length is fixed at entry; OE/SEL only matter on the final edge.
        count_nxt = count - TA_LAST;
        if (count == TA_LAST) begin
          if (req) begin
            state_nxt  = ST_DRIVE;
            drv_ch_nxt = SEL;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode from registered state
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] y_val;

  // Explicit mux so a non-power-of-two bank never indexes past ch_q.
  always_comb begin
    y_val = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (drv_ch == CSW'(i)) begin
        y_val = ch_q[i];
      end
    end
  end

  assign DRV  = (state == ST_DRIVE);
  assign BUSY = (state == ST_TURN);
  assign Y    = DRV ? y_val : {WIDTH{1'bz}};

endmodule

// File: tb/tb_uop_latch_bank.sv
module tb_uop_latch_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic [3:0] le;
  logic [1:0] sel;
  logic       oe;

  always #5 clk = ~clk;

  wire  [7:0]  y_a, y_b, y_c;
  logic [31:0] q_a, q_c;
  logic [23:0] q_b;
  logic        busy_a, busy_b, busy_c;
  logic        drv_a, drv_b, drv_c;

  wire ya_z = (y_a === 8'bzzzzzzzz);
  wire yb_z = (y_b === 8'bzzzzzzzz);
  wire yc_z = (y_c === 8'bzzzzzzzz);

  // A: 4 channels, 2 dead cycles. B: 3 channels, 2 dead cycles. C: 4 channels, none.
  uop_latch_bank #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(2), .RESET_VAL(8'h00)) u_dut_a (
    .CLK(clk), .RESET(reset), .D(d), .LE(le), .SEL(sel), .OE(oe),
    .Y(y_a), .Q(q_a), .BUSY(busy_a), .DRV(drv_a));

  uop_latch_bank #(.WIDTH(8), .CHANNELS(3), .TURNAROUND(2), .RESET_VAL(8'h00)) u_dut_b (
    .CLK(clk), .RESET(reset), .D(d), .LE(le[2:0]), .SEL(sel), .OE(oe),
    .Y(y_b), .Q(q_b), .BUSY(busy_b), .DRV(drv_b));

  uop_latch_bank #(.WIDTH(8), .CHANNELS(4), .TURNAROUND(0), .RESET_VAL(8'h00)) u_dut_c (
    .CLK(clk), .RESET(reset), .D(d), .LE(le), .SEL(sel), .OE(oe),
    .Y(y_c), .Q(q_c), .BUSY(busy_c), .DRV(drv_c));

  // Behavioural reference: who owns the bus (-1 = nobody) and how many dead
  // cycles remain before the bus may be handed out again.
  int         nch [3] = '{4, 3, 4};
  int         ta  [3] = '{2, 2, 0};
  logic [7:0] m_ch   [3][4];
  int         m_drv  [3];
  int         m_dead [3];

  int checks = 0;
  int errors = 0;

  task automatic model_edge();
    bit req;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) m_ch[k][c] = 8'h00;
        m_drv[k]  = -1;
        m_dead[k] = 0;
      end else begin
        req = oe && (int'(sel) < nch[k]);
        if (m_dead[k] > 0) begin
          m_dead[k] = m_dead[k] - 1;
          if (m_dead[k] == 0) m_drv[k] = req ? int'(sel) : -1;
        end else if (m_drv[k] < 0) begin
          if (req) m_drv[k] = int'(sel);
        end else if (!(req && int'(sel) == m_drv[k])) begin
          if (ta[k] > 0) begin
            m_drv[k]  = -1;
            m_dead[k] = ta[k];
          end else begin
            m_drv[k] = req ? int'(sel) : -1;
          end
        end
        for (int c = 0; c < nch[k]; c++) if (le[c]) m_ch[k][c] = d;
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] q, input logic [7:0] y,
                            input logic yz, input logic busy, input logic drv);
    logic [31:0] exp_q;
    logic        exp_drv, exp_busy;
    exp_q = '0;
    for (int c = 0; c < nch[k]; c++) exp_q[c*8 +: 8] = m_ch[k][c];
    exp_drv  = (m_drv[k] >= 0);
    exp_busy = (m_dead[k] > 0);
    checks++;
    assert (q === exp_q) else begin
      errors++; $error("FAIL q[%0d] observed %h expected %h", k, q, exp_q);
    end
    checks++;
    assert (drv === exp_drv) else begin
      errors++; $error("FAIL drv[%0d] observed %b expected %b", k, drv, exp_drv);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++; $error("FAIL busy[%0d] observed %b expected %b", k, busy, exp_busy);
    end
    checks++;
    if (exp_drv) begin
      assert (y === m_ch[k][m_drv[k]]) else begin
        errors++; $error("FAIL y[%0d] observed %h expected %h", k, y, m_ch[k][m_drv[k]]);
      end
    end else begin
      assert (yz === 1'b1) else begin
        errors++; $error("FAIL y_z[%0d] observed %h expected zz", k, y);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++; $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_inst(0, q_a,          y_a, ya_z, busy_a, drv_a);
    check_inst(1, {8'h00, q_b}, y_b, yb_z, busy_b, drv_b);
    check_inst(2, q_c,          y_c, yc_z, busy_c, drv_c);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_drv[k]  = -1;
      m_dead[k] = 0;
      for (int c = 0; c < 4; c++) m_ch[k][c] = 8'h00;
    end

    // Reset dominates OE/LE.
    reset = 1'b1; oe = 1'b1; le = 4'hF; d = 8'hFF; sel = 2'd0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_q_a",    q_a,          32'h0);
    chk("rst_yz_a",   {31'b0, ya_z}, 32'h1);
    chk("rst_busy_a", {31'b0, busy_a}, 32'h0);
    chk("rst_drv_a",  {31'b0, drv_a},  32'h0);
    reset = 1'b0; oe = 1'b0; le = 4'h0;

    // Loads.
    d = 8'hA5; le = 4'b0001; tick();
    d = 8'h3C; le = 4'b0110; tick();
    d = 8'h99; le = 4'b0000; tick();
    chk("load_q_a", q_a, 32'h003C3CA5);
    chk("load_q_b", {8'h00, q_b}, 32'h003C3CA5);
    tick();
    chk("hold_q_a", q_a, 32'h003C3CA5);

    // Drive latency and follow-through of a load on the driven channel.
    oe = 1'b1; sel = 2'd0;
    chk("pre_drv_yz_a", {31'b0, ya_z}, 32'h1);
    tick();
    chk("drv_y_a", {24'h0, y_a}, 32'hA5);
    chk("drv_drv_a", {31'b0, drv_a}, 32'h1);
    le = 4'b0001; d = 8'h77; tick();
    chk("follow_y_a", {24'h0, y_a}, 32'h77);
    le = 4'b0000;

    // Switch 0 -> 1 with OE toggled mid-turnaround.
    sel = 2'd1; tick();
    chk("sw_busy_a", {31'b0, busy_a}, 32'h1);
    chk("sw_direct_y_c", {24'h0, y_c}, 32'h3C);
    oe = 1'b0; tick();
    chk("sw_busy2_a", {31'b0, busy_a}, 32'h1);
    oe = 1'b1; tick();
    chk("sw_y_a", {24'h0, y_a}, 32'h3C);
    chk("sw_busy3_a", {31'b0, busy_a}, 32'h0);

    // Release.
    oe = 1'b0; tick();
    chk("rel_busy1_a", {31'b0, busy_a}, 32'h1);
    tick();
    chk("rel_busy2_a", {31'b0, busy_a}, 32'h1);
    tick();
    chk("rel_busy3_a", {31'b0, busy_a}, 32'h0);
    chk("rel_drv_a",   {31'b0, drv_a},  32'h0);

    // Out-of-range SEL on the 3-channel bank.
    oe = 1'b1; sel = 2'd3; tick();
    chk("inv_drv_b", {31'b0, drv_b}, 32'h0);
    chk("inv_yz_b",  {31'b0, yb_z},  32'h1);
    tick();
    chk("inv_drv2_b", {31'b0, drv_b}, 32'h0);

    // Reset during turnaround.
    sel = 2'd0; tick();
    chk("mid_busy_a", {31'b0, busy_a}, 32'h1);
    reset = 1'b1; tick();
    chk("mid_rst_busy_a", {31'b0, busy_a}, 32'h0);
    chk("mid_rst_yz_a",   {31'b0, ya_z},   32'h1);
    reset = 1'b0; oe = 1'b0;

    // Zero-turnaround direct switch.
    d = 8'h11; le = 4'b0001; tick();
    d = 8'h22; le = 4'b0100; tick();
    le = 4'b0000; oe = 1'b1; sel = 2'd0; tick();
    chk("ta0_y0_c", {24'h0, y_c}, 32'h11);
    sel = 2'd2; tick();
    chk("ta0_y2_c",   {24'h0, y_c},   32'h22);
    chk("ta0_busy_c", {31'b0, busy_c}, 32'h0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      d     = 8'($urandom);
      le    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 4) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 6) == 0) oe = ~oe;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
